// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared mode encodings and channel state type for the LED sequencer
package led_ctrl_pkg;

  localparam logic [1:0] LED_OFF   = 2'd0;
  localparam logic [1:0] LED_ON    = 2'd1;
  localparam logic [1:0] LED_BLINK = 2'd2;
  localparam logic [1:0] LED_BURST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_BLINK,
    ST_BURST
  } chan_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - free-running prescaler producing a one-cycle half-period tick
module led_tick_gen #(
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - command-driven OFF/ON/BLINK/BURST sequencer for a bank of LEDs
// Optional PWM dimming is enabled by defining LED_PWM_DIM_EN.
module led_seq_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS    = 4,
  parameter int TICK_CYCLES = 25_000_000,
  parameter int CNT_W       = 8,
  localparam int CH_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef LED_PWM_DIM_EN
  input  logic [3:0]          dim,
`endif
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CH_W-1:0]     cmd_chan,
  input  logic [1:0]          cmd_mode,
  input  logic [CNT_W-1:0]    cmd_count,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] busy,
  output logic [NUM_LEDS-1:0] done
);

  logic                tick;
  logic                accept;
  logic [NUM_LEDS-1:0] led_int;

  led_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Only a running burst holds off commands; OFF always gets through so it can abort.
  always_comb begin
    cmd_ready = 1'b1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (cmd_chan == CH_W'(i) && busy[i] && cmd_mode != LED_OFF) begin
        cmd_ready = 1'b0;
      end
    end
  end

  assign accept = cmd_valid && cmd_ready;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    chan_state_t      state;
    logic [CNT_W-1:0] remaining;
    logic             led_q;
    logic             busy_q;
    logic             done_q;
    logic             sel;

    assign sel = accept && (cmd_chan == CH_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= ST_IDLE;
        remaining <= '0;
        led_q     <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (sel) begin
          case (cmd_mode)
            LED_OFF: begin
              state  <= ST_IDLE;
              led_q  <= 1'b0;
              busy_q <= 1'b0;
            end
            LED_ON: begin
              state  <= ST_ON;
              led_q  <= 1'b1;
              busy_q <= 1'b0;
            end
            LED_BLINK: begin
              state  <= ST_BLINK;
              led_q  <= 1'b1;
              busy_q <= 1'b0;
            end
            default: begin
              led_q <= 1'b0;
              if (cmd_count == '0) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                state     <= ST_BURST;
                busy_q    <= 1'b1;
                remaining <= cmd_count;
              end
            end
          endcase
        end else if (tick) begin
          case (state)
            ST_BLINK: led_q <= ~led_q;
            ST_BURST: begin
              if (!led_q) begin
                led_q <= 1'b1;
              end else begin
                // Falling edge closes one on-phase; the last one ends the burst.
                led_q <= 1'b0;
                if (remaining <= CNT_W'(1)) begin
                  remaining <= '0;
                  state     <= ST_IDLE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                end else begin
                  remaining <= remaining - CNT_W'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign led_int[i] = led_q;
    assign busy[i]    = busy_q;
    assign done[i]    = done_q;
  end

`ifdef LED_PWM_DIM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign led = led_int & {NUM_LEDS{pwm_cnt <= dim}};
`else
  assign led = led_int;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - randomized scoreboard bench for led_seq_ctrl
module tb_led_seq_ctrl;

  localparam int NL = 4;
  localparam int TK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_chan;
  logic [1:0]    cmd_mode;
  logic [7:0]    cmd_count;
  logic [NL-1:0] led, busy, done;

  logic       cmd_valid3;
  logic       cmd_ready3;
  logic [1:0] cmd_chan3;
  logic [1:0] cmd_mode3;
  logic [7:0] cmd_count3;
  logic [2:0] led3, busy3, done3;

  led_seq_ctrl #(.NUM_LEDS(NL), .TICK_CYCLES(TK), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan),
    .cmd_mode(cmd_mode), .cmd_count(cmd_count),
    .led(led), .busy(busy), .done(done)
  );

  led_seq_ctrl #(.NUM_LEDS(3), .TICK_CYCLES(TK), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_chan(cmd_chan3),
    .cmd_mode(cmd_mode3), .cmd_count(cmd_count3),
    .led(led3), .busy(busy3), .done(done3)
  );

  typedef struct { bit v; int c; int m; int n; } cmd_t;
  typedef struct { logic [NL-1:0] led; logic [NL-1:0] busy; logic [NL-1:0] done; logic rdy; } exp_t;

  cmd_t stim[$];
  exp_t expq[$];
  cmd_t cur;
  int   errors = 0;
  int   checks = 0;
  int   p;
  bit   rand_en;
  bit   exp_rdy;
  bit   rset[NL];
  int   rmode[NL];
  int   rn[NL];
  int   ra[NL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge=%0d: got %0h expected %0h", name, p, act, req);
    end
  endtask

  // Ticks seen strictly after acceptance edge a up to edge t; the tick at edge p fires when p%TK==TK-1.
  function automatic int kt(input int a, input int t);
    return (t + 1) / TK - (a + 1) / TK;
  endfunction

  function automatic bit bact(input int c, input int t);
    return rset[c] && rmode[c] == 3 && kt(ra[c], t) < 2 * rn[c];
  endfunction

  function automatic void add(input bit v, input int c, input int m, input int n);
    cmd_t x;
    x.v = v; x.c = c; x.m = m; x.n = n;
    stim.push_back(x);
  endfunction

  function automatic void idle(input int cycles);
    for (int i = 0; i < cycles; i++) add(1'b0, 0, 0, 0);
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NL; c++) begin
      rset[c] = 1'b0; rmode[c] = 0; rn[c] = 0; ra[c] = 0;
    end
  endfunction

  task automatic step();
    exp_t e;
    int   k;
    @(posedge clk);
    #1;
    p++;
    if (!cur.v || exp_rdy) begin
      if (cur.v && cur.c < NL) begin
        rset[cur.c]  = 1'b1;
        rmode[cur.c] = cur.m;
        rn[cur.c]    = cur.n;
        ra[cur.c]    = p;
      end
      if (stim.size() > 0) begin
        cur = stim.pop_front();
      end else if (rand_en) begin
        cur.v = ($urandom_range(0, 2) == 0);
        cur.c = $urandom_range(0, NL - 1);
        cur.m = $urandom_range(0, 3);
        cur.n = $urandom_range(0, 3);
      end else begin
        cur = '{1'b0, 0, 0, 0};
      end
    end
    cmd_valid = cur.v;
    cmd_chan  = cur.c[1:0];
    cmd_mode  = cur.m[1:0];
    cmd_count = cur.n[7:0];
    exp_rdy   = !(cur.c < NL && bact(cur.c, p) && cur.m != 0);
    e.led = '0; e.busy = '0; e.done = '0; e.rdy = exp_rdy;
    for (int c = 0; c < NL; c++) begin
      if (rset[c]) begin
        k = kt(ra[c], p);
        case (rmode[c])
          1: e.led[c] = 1'b1;
          2: e.led[c] = (k % 2 == 0);
          3: begin
            e.busy[c] = (k < 2 * rn[c]);
            e.led[c]  = e.busy[c] && (k % 2 == 1);
            e.done[c] = (k == 2 * rn[c]) && (p == ra[c] || p % TK == TK - 1);
          end
          default: ;
        endcase
      end
    end
    expq.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("cmd_ready", cmd_ready, e.rdy);
        chk("led", led, e.led);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
      end
    end
  end

  initial begin
    cmd_valid = 0; cmd_chan = 0; cmd_mode = 0; cmd_count = 0;
    cmd_valid3 = 0; cmd_chan3 = 0; cmd_mode3 = 0; cmd_count3 = 0;
    cur = '{1'b0, 0, 0, 0};
    exp_rdy = 1'b1;
    p = -1;
    rand_en = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    #2;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    add(1, 0, 1, 0); add(1, 1, 2, 0); idle(2);
    add(1, 2, 3, 3); idle(3); add(1, 2, 2, 0); idle(6);
    add(1, 2, 3, 2); idle(5); add(1, 2, 0, 0); idle(3);
    add(1, 3, 3, 0); idle(3);
    repeat (80) step();

    rand_en = 1'b1;
    repeat (600) step();

    rand_en = 1'b0;
    for (int c = 0; c < NL; c++) add(1, c, 0, 0);
    add(1, 0, 1, 0); add(1, 2, 3, 20); add(1, 2, 2, 0);
    repeat (40) step();
    @(negedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", led, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_ready", cmd_ready, 1);
    cur = '{1'b0, 0, 0, 0};
    cmd_valid = 0;
    model_clear();
    p = -1;
    exp_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (40) step();
    rand_en = 1'b1;
    repeat (200) step();
    rand_en = 1'b0;
    repeat (30) step();

    @(negedge clk);
    cmd_valid3 = 1; cmd_chan3 = 2'd3; cmd_mode3 = 2'd1;
    #1;
    chk("oob_ready", cmd_ready3, 1);
    @(posedge clk);
    #1;
    cmd_valid3 = 0;
    @(negedge clk);
    chk("oob_led", led3, 0);
    chk("oob_busy", busy3, 0);
    cmd_valid3 = 1; cmd_chan3 = 2'd2; cmd_mode3 = 2'd1;
    @(posedge clk);
    #1;
    cmd_valid3 = 0;
    @(negedge clk);
    chk("ch2_on_led", led3, 3'b100);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
